tile_order_reader: RTL and testbench

// - Consumer side of the board-order generator: latches one packed edge-ring order and one center-tile order,

---
 rtl/tile_order_pkg.sv | 35 +++
 rtl/ring_pos_inc.sv | 12 +
 rtl/tile_order_reader.sv | 154 +++++++++++++++
 tb/tb_tile_order_reader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_order_pkg.sv
// Shared constants, request kinds and FSM encodings for the tile-order consumer.
package tile_order_pkg;

  localparam int EDGE_TILES   = 24;
  localparam int CENTER_TILES = 12;
  localparam int SYM_W        = 4;
  localparam int IDX_W        = 5;

  localparam logic [1:0] KIND_EDGE_READ   = 2'd0;
  localparam logic [1:0] KIND_CENTER_READ = 2'd1;
  localparam logic [1:0] KIND_EDGE_SEEK   = 2'd2;

  // Reads resolve in the accept cycle and go straight to RESP;
  // only seeks spend time in SCAN.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [SYM_W-1:0] pick_edge(
    input logic [EDGE_TILES*SYM_W-1:0] order,
    input logic [IDX_W-1:0]            idx
  );
    return order[int'(idx)*SYM_W +: SYM_W];
  endfunction

  function automatic logic [SYM_W-1:0] pick_center(
    input logic [CENTER_TILES*SYM_W-1:0] order,
    input logic [IDX_W-1:0]              idx
  );
    return order[int'(idx)*SYM_W +: SYM_W];
  endfunction

endpackage

// File: rtl/ring_pos_inc.sv
// Edge-ring position increment: pos+1, wrapping from EDGE_TILES-1 back to 0.
module ring_pos_inc
  import tile_order_pkg::*;
(
  input  logic [IDX_W-1:0] pos,
  output logic [IDX_W-1:0] next
);

  // Compare-and-wrap keeps this a plain adder plus mux.
  assign next = (pos == IDX_W'(EDGE_TILES - 1)) ? '0 : pos + 1'b1;

endmodule

// File: rtl/tile_order_reader.sv
// Latches an edge-ring order and a center order, then answers read and
// seek requests against them.
//
// Handshake: a request transfers on a clock edge where req_valid & req_ready;
// a response transfers on a clock edge where rsp_valid & rsp_ready, and all
// rsp_* hold steady from the rise of rsp_valid until that transfer.
module tile_order_reader
  import tile_order_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [EDGE_TILES*SYM_W-1:0]   edge_order_in,
  input  logic [CENTER_TILES*SYM_W-1:0] center_order_in,
  output logic                          loaded,
  output logic                          load_drop,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_kind,
  input  logic [IDX_W-1:0]              req_idx,
  input  logic [SYM_W-1:0]              req_sym,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [SYM_W-1:0]              rsp_sym,
  output logic [IDX_W-1:0]              rsp_pos,
  output logic                          rsp_found,
  output logic                          rsp_err,
  output logic [1:0]                    fsm_state
);

  state_t                        state;
  logic [EDGE_TILES*SYM_W-1:0]   edge_q;
  logic [CENTER_TILES*SYM_W-1:0] center_q;
  logic [SYM_W-1:0]              sym_q;
  logic [IDX_W-1:0]              start_q;
  logic [IDX_W-1:0]              pos_q;
  logic [IDX_W-1:0]              step_q;
  logic [IDX_W-1:0]              inc_in;
  logic [IDX_W-1:0]              pos_next;
  logic                          accept;
  logic                          bad_req;

  assign req_ready = (state == ST_IDLE) && !load;
  assign accept    = req_valid && req_ready;
  assign fsm_state = state;

  // One incrementer serves both the first seek step (from req_idx) and the scan walk.
  always_comb begin
    inc_in = pos_q;
    if (state == ST_IDLE) inc_in = req_idx;
  end

  ring_pos_inc u_inc (
    .pos  (inc_in),
    .next (pos_next)
  );

  // Requests that must be answered with an error instead of a lookup.
  always_comb begin
    bad_req = 1'b0;
    case (req_kind)
      KIND_EDGE_READ,
      KIND_EDGE_SEEK:   bad_req = (req_idx >= IDX_W'(EDGE_TILES));
      KIND_CENTER_READ: bad_req = (req_idx >= IDX_W'(CENTER_TILES));
      default:          bad_req = 1'b1;
    endcase
    if (!loaded) bad_req = 1'b1;
  end

  // Order capture, request FSM and registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      edge_q    <= '0;
      center_q  <= '0;
      sym_q     <= '0;
      start_q   <= '0;
      pos_q     <= '0;
      step_q    <= '0;
      loaded    <= 1'b0;
      load_drop <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sym   <= '0;
      rsp_pos   <= '0;
      rsp_found <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      load_drop <= 1'b0;
      if (load) begin
        if (state == ST_IDLE) begin
          edge_q   <= edge_order_in;
          center_q <= center_order_in;
          loaded   <= 1'b1;
        end else begin
          load_drop <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            rsp_pos   <= req_idx;
            rsp_sym   <= '0;
            rsp_found <= 1'b0;
            rsp_err   <= 1'b0;
            if (bad_req) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else if (req_kind == KIND_EDGE_SEEK) begin
              sym_q   <= req_sym;
              start_q <= req_idx;
              pos_q   <= pos_next;
              step_q  <= IDX_W'(1);
              state   <= ST_SCAN;
            end else begin
              rsp_sym   <= (req_kind == KIND_EDGE_READ) ? pick_edge(edge_q, req_idx)
                                                        : pick_center(center_q, req_idx);
              rsp_found <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end
        ST_SCAN: begin
          if (pick_edge(edge_q, pos_q) == sym_q) begin
            rsp_pos   <= pos_q;
            rsp_sym   <= sym_q;
            rsp_found <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (step_q == IDX_W'(EDGE_TILES - 1)) begin
            rsp_pos   <= start_q;
            rsp_sym   <= '0;
            rsp_found <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            pos_q  <= pos_next;
            step_q <= step_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_order_reader.sv
// Directed bench for tile_order_reader: reads, seeks, errors, load drop,
// response back-pressure and asynchronous reset mid-scan.
module tb_tile_order_reader;
  import tile_order_pkg::*;

  logic                          clk;
  logic                          rst;
  logic                          load;
  logic [EDGE_TILES*SYM_W-1:0]   edge_order_in;
  logic [CENTER_TILES*SYM_W-1:0] center_order_in;
  logic                          loaded;
  logic                          load_drop;
  logic                          req_valid;
  logic                          req_ready;
  logic [1:0]                    req_kind;
  logic [IDX_W-1:0]              req_idx;
  logic [SYM_W-1:0]              req_sym;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [SYM_W-1:0]              rsp_sym;
  logic [IDX_W-1:0]              rsp_pos;
  logic                          rsp_found;
  logic                          rsp_err;
  logic [1:0]                    fsm_state;

  tile_order_reader dut (
    .clk             (clk),
    .rst             (rst),
    .load            (load),
    .edge_order_in   (edge_order_in),
    .center_order_in (center_order_in),
    .loaded          (loaded),
    .load_drop       (load_drop),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_kind        (req_kind),
    .req_idx         (req_idx),
    .req_sym         (req_sym),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_sym         (rsp_sym),
    .rsp_pos         (rsp_pos),
    .rsp_found       (rsp_found),
    .rsp_err         (rsp_err),
    .fsm_state       (fsm_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Entry layout: {err, found, pos[4:0], sym[3:0], check_pos}
  logic [11:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int acc_cyc  = 0;

  logic [EDGE_TILES*SYM_W-1:0]   order_a_edge;
  logic [CENTER_TILES*SYM_W-1:0] order_a_center;
  logic [EDGE_TILES*SYM_W-1:0]   order_b_edge;
  logic [CENTER_TILES*SYM_W-1:0] order_b_center;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_orders(input logic [EDGE_TILES*SYM_W-1:0] e,
                             input logic [CENTER_TILES*SYM_W-1:0] c);
    @(negedge clk);
    load            = 1'b1;
    edge_order_in   = e;
    center_order_in = c;
    @(posedge clk);
    #1;
    load = 1'b0;
    @(negedge clk);
    check("loaded_after_load", loaded, 1);
  endtask

  task automatic send_req(input logic [1:0] kind, input logic [IDX_W-1:0] idx,
                          input logic [SYM_W-1:0] sym, input logic e_err,
                          input logic e_found, input logic [IDX_W-1:0] e_pos,
                          input logic [SYM_W-1:0] e_sym);
    @(negedge clk);
    req_valid = 1'b1;
    req_kind  = kind;
    req_idx   = idx;
    req_sym   = sym;
    check("req_ready_idle", req_ready, 1);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    // Scramble request fields: the DUT must have registered them already.
    req_kind  = 2'($urandom_range(0, 3));
    req_idx   = IDX_W'($urandom_range(0, 31));
    req_sym   = SYM_W'($urandom_range(0, 15));
    exp_q.push_back({e_err, e_found, e_pos, e_sym, ~e_err});
  endtask

  task automatic wait_rsp(input int exp_lat, input int hold);
    logic        got;
    logic [11:0] e;
    logic [SYM_W-1:0] s_sym;
    logic [IDX_W-1:0] s_pos;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    e = exp_q.pop_front();
    if (!got) begin
      check("rsp_timeout", rsp_valid, 1);
    end else begin
      check("rsp_latency", 32'(cyc - acc_cyc + 1), 32'(exp_lat));
      check("rsp_err", rsp_err, e[11]);
      check("rsp_found", rsp_found, e[10]);
      check("rsp_sym", rsp_sym, e[4:1]);
      if (e[0]) check("rsp_pos", rsp_pos, e[9:5]);
      s_sym = rsp_sym;
      s_pos = rsp_pos;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", rsp_valid, 1);
        check("hold_sym", rsp_sym, s_sym);
        check("hold_pos", rsp_pos, s_pos);
        check("hold_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst             = 1'b0;
    load            = 1'b0;
    edge_order_in   = '0;
    center_order_in = '0;
    req_valid       = 1'b0;
    req_kind        = '0;
    req_idx         = '0;
    req_sym         = '0;
    rsp_ready       = 1'b0;

    for (int i = 0; i < EDGE_TILES; i++) begin
      order_a_edge[i*SYM_W +: SYM_W] = SYM_W'(i % 16);
      order_b_edge[i*SYM_W +: SYM_W] = (i == 5) ? SYM_W'(3) : SYM_W'(9);
    end
    for (int j = 0; j < CENTER_TILES; j++) begin
      order_a_center[j*SYM_W +: SYM_W] = SYM_W'(15 - j);
      order_b_center[j*SYM_W +: SYM_W] = SYM_W'(j);
    end

    repeat (3) @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_loaded", loaded, 0);
    check("reset_load_drop", load_drop, 0);
    check("reset_rsp_sym", rsp_sym, 0);
    check("reset_state", fsm_state, 0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_req_ready", req_ready, 1);

    // Read before any load is an error.
    send_req(KIND_EDGE_READ, 5'd3, 4'd0, 1'b1, 1'b0, 5'd3, 4'd0);
    wait_rsp(1, 0);

    // Order A: edge i = i%16, center j = 15-j.
    load_orders(order_a_edge, order_a_center);
    send_req(KIND_EDGE_READ, 5'd23, 4'd0, 1'b0, 1'b1, 5'd23, 4'd7);
    wait_rsp(1, 0);
    send_req(KIND_CENTER_READ, 5'd0, 4'd0, 1'b0, 1'b1, 5'd0, 4'd15);
    wait_rsp(1, 0);
    send_req(KIND_CENTER_READ, 5'd11, 4'd0, 1'b0, 1'b1, 5'd11, 4'd4);
    wait_rsp(1, 0);

    // Seek with wrap: 21,22,23,0,1 -> match at k=5.
    send_req(KIND_EDGE_SEEK, 5'd20, 4'd1, 1'b0, 1'b1, 5'd1, 4'd1);
    wait_rsp(6, 0);
    // Start at the last position, match right after wrap.
    send_req(KIND_EDGE_SEEK, 5'd23, 4'd0, 1'b0, 1'b1, 5'd0, 4'd0);
    wait_rsp(2, 0);
    // Start tile 7 holds 7 but is skipped; next 7 is at position 23 (k=16).
    send_req(KIND_EDGE_SEEK, 5'd7, 4'd7, 1'b0, 1'b1, 5'd23, 4'd7);
    wait_rsp(17, 0);

    // Error cases.
    send_req(KIND_CENTER_READ, 5'd12, 4'd0, 1'b1, 1'b0, 5'd12, 4'd0);
    wait_rsp(1, 0);
    send_req(KIND_EDGE_READ, 5'd24, 4'd0, 1'b1, 1'b0, 5'd24, 4'd0);
    wait_rsp(1, 0);
    send_req(2'd3, 5'd1, 4'd0, 1'b1, 1'b0, 5'd1, 4'd0);
    wait_rsp(1, 0);

    // Order B: all 9 except tile 5 = 3. Seek for 3 from 5 never matches.
    load_orders(order_b_edge, order_b_center);
    send_req(KIND_EDGE_SEEK, 5'd5, 4'd3, 1'b0, 1'b0, 5'd5, 4'd0);
    wait_rsp(24, 0);

    // Load arriving mid-scan is dropped; the seek sees order B (match at 5, not 3).
    send_req(KIND_EDGE_SEEK, 5'd0, 4'd3, 1'b0, 1'b1, 5'd5, 4'd3);
    @(negedge clk);
    load            = 1'b1;
    edge_order_in   = order_a_edge;
    center_order_in = order_a_center;
    @(posedge clk);
    #1;
    load = 1'b0;
    @(negedge clk);
    check("load_drop_pulse", load_drop, 1);
    check("loaded_kept", loaded, 1);
    @(negedge clk);
    check("load_drop_one_cycle", load_drop, 0);
    wait_rsp(6, 0);
    send_req(KIND_EDGE_READ, 5'd3, 4'd0, 1'b0, 1'b1, 5'd3, 4'd9);
    wait_rsp(1, 0);

    // Back-pressure: response held for 10 cycles.
    send_req(KIND_CENTER_READ, 5'd7, 4'd0, 1'b0, 1'b1, 5'd7, 4'd7);
    wait_rsp(1, 10);

    // Asynchronous reset in the middle of a scan.
    send_req(KIND_EDGE_SEEK, 5'd5, 4'd3, 1'b0, 1'b0, 5'd5, 4'd0);
    repeat (5) @(negedge clk);
    check("scan_before_reset", fsm_state, 1);
    #2;
    rst = 1'b0;
    #1;
    check("midscan_rsp_valid", rsp_valid, 0);
    check("midscan_loaded", loaded, 0);
    check("midscan_state", fsm_state, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_state", fsm_state, 0);
    check("post_reset_rsp_valid", rsp_valid, 0);
    send_req(KIND_EDGE_READ, 5'd2, 4'd0, 1'b1, 1'b0, 5'd2, 4'd0);
    wait_rsp(1, 0);

    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
